// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer for the mini CPU: T0-T2 fetch, T3-T7 opcode-dependent execute.
// Latency: 3 fetch cycles + 1..5 execute cycles per instruction; strobes are Moore decodes of state.
// Backpressure: stop parks the sequencer in PAUSE at an instruction boundary; halt is absorbing until reset.
module control_unit (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] opcode,
    input  logic       con_ff,
    input  logic       stop,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       Rin,
    output logic       Rout,
    output logic       BAout,
    output logic       PCout,
    output logic       MDRout,
    output logic       Zhighout,
    output logic       Zlowout,
    output logic       HIout,
    output logic       LOout,
    output logic       Cout,
    output logic       InPortout,
    output logic       PCin,
    output logic       IRin,
    output logic       MARin,
    output logic       MDRin,
    output logic       Yin,
    output logic       Zin,
    output logic       HIin,
    output logic       LOin,
    output logic       OutPortin,
    output logic       CONin,
    output logic       IncPC,
    output logic       Read,
    output logic       Write,
    output logic [4:0] alu_op,
    output logic       run
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state, state_n;
    logic [4:0] op_q;
    logic [4:0] op;
    logic       c_alu, c_imm, c_mem, c_ld, c_st, c_md, c_neg, c_br;
    logic [4:0] imm_alu;
    state_t     last_t3, last_q;
    state_t     boundary;

    // Last execute step of an instruction class; everything not listed finishes in T3.
    function automatic state_t last_step(input logic [4:0] o);
        if ((o >= OP_ADD && o <= OP_ORI) || o == OP_LDI) return S_T5;
        if (o == OP_LD || o == OP_ST)                    return S_T7;
        if (o == OP_DIV || o == OP_MUL || o == OP_BR)    return S_T6;
        if (o == OP_NEG || o == OP_NOT)                  return S_T4;
        return S_T3;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_RST;
            op_q  <= 5'b00000;
        end else begin
            state <= state_n;
            if (state == S_T3) op_q <= opcode;
        end
    end

    always_comb begin
        last_t3  = last_step(opcode);
        last_q   = last_step(op_q);
        boundary = stop ? S_PAUSE : S_T0;
        state_n  = state;
        case (state)
            S_RST:   state_n = S_T0;
            S_T0:    state_n = S_T1;
            S_T1:    state_n = S_T2;
            S_T2:    state_n = S_T3;
            S_T3: begin
                if (opcode == OP_HALT)     state_n = S_HALT;
                else if (last_t3 == S_T3)  state_n = boundary;
                else                       state_n = S_T4;
            end
            S_T4:    state_n = (last_q == S_T4) ? boundary : S_T5;
            S_T5:    state_n = (last_q == S_T5) ? boundary : S_T6;
            S_T6:    state_n = (last_q == S_T6) ? boundary : S_T7;
            S_T7:    state_n = boundary;
            S_PAUSE: state_n = stop ? S_PAUSE : S_T0;
            S_HALT:  state_n = S_HALT;
            default: state_n = S_RST;
        endcase
    end

    // T3 decodes the live opcode; later steps use the copy captured during T3.
    always_comb begin
        op      = (state == S_T3) ? opcode : op_q;
        c_alu   = (op >= OP_ADD && op <= OP_SHL);
        c_imm   = (op >= OP_ADDI && op <= OP_ORI);
        c_ld    = (op == OP_LD);
        c_st    = (op == OP_ST);
        c_mem   = c_ld || c_st || (op == OP_LDI);
        c_md    = (op == OP_DIV) || (op == OP_MUL);
        c_neg   = (op == OP_NEG) || (op == OP_NOT);
        c_br    = (op == OP_BR);
        imm_alu = (op == OP_ANDI) ? OP_AND : (op == OP_ORI) ? OP_OR : OP_ADD;
    end

    always_comb begin
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        PCout = 1'b0; MDRout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; Cout = 1'b0; InPortout = 1'b0;
        PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
        HIin = 1'b0; LOin = 1'b0; OutPortin = 1'b0; CONin = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
        alu_op = 5'b00000;
        run    = 1'b1;
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (c_alu || c_imm)  begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                else if (c_mem)      begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                else if (c_md)       begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                else if (c_neg)      begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
                else if (c_br)       begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                else if (op == OP_JR)   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                else if (op == OP_IN)   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (op == OP_OUT)  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                else if (op == OP_MFHI) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (op == OP_MFLO) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            S_T4: begin
                if (c_alu)       begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
                else if (c_imm)  begin Cout = 1'b1; Zin = 1'b1; alu_op = imm_alu; end
                else if (c_mem)  begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
                else if (c_md)   begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
                else if (c_neg)  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (c_br)   begin PCout = 1'b1; Yin = 1'b1; end
            end
            S_T5: begin
                if (c_ld || c_st)                  begin Zlowout = 1'b1; MARin = 1'b1; end
                else if (c_alu || c_imm || c_mem)  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (c_md)                     begin Zlowout = 1'b1; LOin = 1'b1; end
                else if (c_br)                     begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
            end
            S_T6: begin
                if (c_ld)                  begin Read = 1'b1; MDRin = 1'b1; end
                else if (c_st)             begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                else if (c_md)             begin Zhighout = 1'b1; HIin = 1'b1; end
                else if (c_br && con_ff)   begin Zlowout = 1'b1; PCin = 1'b1; end
            end
            S_T7: begin
                if (c_ld)       begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (c_st)  Write = 1'b1;
            end
            S_PAUSE, S_HALT: run = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the mini CPU datapath. It steps each instruction through fetch (T0–T2) and opcode-dependent execute steps (T3–T7). It drives the register-select strobes (Gra/Grb/Grc/Rin/Rout/BAout) consumed by the select/encode unit, plus all bus-out, register-in, ALU and memory strobes. It sits between the IR-derived `opcode` and the datapath, and owns run/halt state.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces state RST.
- opcode  in  5  IR[31:27] from the select/encode unit; valid from T3.
- con_ff  in  1  branch condition flag; sampled in br step T6.
- stop  in  1  pause request; honoured only at instruction boundary.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select strobes.
- PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, InPortout  out  1 each  bus drivers.
- PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin, CONin  out  1 each  register loads.
- IncPC, Read, Write  out  1 each  PC-increment ALU mode, memory read, memory write.
- alu_op  out  5  ALU function code; 5'b00000 when no ALU step.
- run  out  1  high unless HALT or PAUSE.

## Operation
- States: RST, T0–T7, PAUSE, HALT. op_q (5b) latched from `opcode` on T3 entry. Execute steps T4–T7 decode op_q; T3 decodes live `opcode`.
- Outputs are Moore decodes of state/op_q, except PCin/Zlowout in br T6, which also depend on con_ff. Any strobe not listed for a step is 0.
- RST: all outputs 0, run=1. Next state is T0.
- Fetch: T0 PCout MARin IncPC Zin. T1 Zlowout PCin Read MDRin. T2 MDRout IRin.
- ALU reg (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
  - T3 Grb Rout Yin. T4 Grc Rout Zin alu_op=op_q. T5 Zlowout Gra Rin. Done.
- ALU imm (addi 01100 →00011, andi 01101 →00101, ori 01110 →00110):
  - T3 Grb Rout Yin. T4 Cout Zin alu_op=mapped code. T5 Zlowout Gra Rin.
- ldi 00001: T3 Grb BAout Yin. T4 Cout Zin alu_op=00011. T5 Zlowout Gra Rin.
- ld 00000: as ldi through T4. T5 Zlowout MARin. T6 Read MDRin. T7 MDRout Gra Rin.
- st 00010: as ld through T5. T6 Gra Rout MDRin. T7 Write.
- div 01111 / mul 10000: T3 Gra Rout Yin. T4 Grb Rout Zin alu_op=op_q. T5 Zlowout LOin. T6 Zhighout HIin.
- neg 10001 / not 10010: T3 Grb Rout Zin alu_op=opcode. T4 Zlowout Gra Rin.
- br 10011: T3 Gra Rout CONin. T4 PCout Yin. T5 Cout Zin alu_op=00011. T6 Zlowout PCin only if con_ff=1, else no strobes.
- jr 10100: T3 Gra Rout PCin.
- in 10110: T3 InPortout Gra Rin. out 10111: T3 Gra Rout OutPortin.
- mfhi 11000: T3 HIout Gra Rin. mflo 11001: T3 LOout Gra Rin.
- nop 11010 and all undefined opcodes (10101, 11100–11111): T3 no strobes.
- halt 11011: T3 no strobes, then HALT.
- Boundary rules:
  - After an instruction's last step, the next state is T0, or PAUSE if stop=1 in that cycle.
  - PAUSE: all strobes 0, run=0. Stays while stop=1; goes to T0 the cycle after stop=0.
  - HALT: all strobes 0, run=0. Absorbing; only reset exits it.
  - reset asserted in any state, mid-instruction included: immediately RST, outputs 0, op_q cleared.

## Timing
- Reset release: RST for 1 cycle, then T0 on the next edge.
- Per-instruction cycle counts: 3 fetch + execute.
  - Execute steps: ALU reg/imm, ldi = 3; ld, st = 5; mul, div, br = 4; neg, not = 2; jr, in, out, mfhi, mflo, nop = 1.
- Totals: add = 6 cycles; ld = 8 cycles.
- Memory has fixed 1-cycle latency; Read and Write are each single-cycle pulses.
- con_ff must be stable during br T6 (it is set by CONin in T3).

## Test plan
- Reset → run=1 and all strobes 0. Next edge T0: PCout=MARin=IncPC=Zin=1.
- opcode=00011 (add) → 6-cycle sequence. T4 shows Grc=Rout=Zin=1, alu_op=00011. T5 shows Zlowout=Gra=Rin=1. Cycle 7 is T0.
- opcode=00000 (ld) → Read=1 in T1 and T6 only. T7 shows MDRout=Gra=Rin=1. Next instruction's T0 is at cycle 9.
- opcode=10011 with con_ff=0, then con_ff=1 → PCin=0 in T6 for the first case, PCin=Zlowout=1 in T6 for the second.
- stop=1 raised during an add's T4 → add completes through T5, then PAUSE with run=0. Drop stop → T0 on the following edge.
- opcode=11011 (halt) → HALT with run=0 indefinitely. Reset asserted mid-ld T5 → outputs 0 asynchronously, then RST→T0.
